// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the requesters/regfile and regfile_wb_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding pipeline.
interface regfile_wb_arbiter_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               we3;
  logic [AW-1:0]      wa3;
  logic [DW-1:0]      wd3;
  logic [(1<<AW)-1:0] pend_mask;
  logic [DW-1:0]      rf_rd1;
  logic [DW-1:0]      rf_rd2;
  logic [AW-1:0]      ra1;
  logic [AW-1:0]      ra2;
  logic [DW-1:0]      fwd_rd1;
  logic [DW-1:0]      fwd_rd2;

  modport slave (
    input  req_valid, req_addr, req_data, rf_rd1, rf_rd2, ra1, ra2,
    output req_ready, we3, wa3, wd3, pend_mask, fwd_rd1, fwd_rd2
  );

  modport master (
    output req_valid, req_addr, req_data, rf_rd1, rf_rd2, ra1, ra2,
    input  req_ready, we3, wa3, wd3, pend_mask, fwd_rd1, fwd_rd2
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the single regfile write port among NREQ write-back
// requesters, each with a 1-entry holding buffer; write-port outputs are registered.
// Optional feature: define WB_FWD_EN to forward the in-flight write-port value onto
// fwd_rd1/fwd_rd2; otherwise those simply pass rf_rd1/rf_rd2 through.
module regfile_wb_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  regfile_wb_arbiter_if.slave bus
);
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    r_full;
  logic [AW-1:0]      r_addr [NREQ];
  logic [DW-1:0]      r_data [NREQ];
  logic [PW-1:0]      r_ptr;
  logic               r_we3;
  logic [AW-1:0]      r_wa3;
  logic [DW-1:0]      r_wd3;

  logic               w_gnt_vld;
  logic [PW-1:0]      w_gnt;
  logic [PW-1:0]      w_ptr_nxt;
  logic [(1<<AW)-1:0] w_pend;

  // Grant: first full buffer at or after the pointer, else wrap to the lowest full one
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    // Descending loops so the lowest qualifying index is assigned last
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (r_full[i]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = PW'(i);
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (r_full[i] && (PW'(i) >= r_ptr)) begin
        w_gnt = PW'(i);
      end
    end
  end

  // Pointer advances to the slot after the winner, wrapping at NREQ-1
  always_comb begin
    w_ptr_nxt = (w_gnt == PW'(NREQ - 1)) ? '0 : w_gnt + PW'(1);
  end

  // Holding buffers: drain on grant, load on handshake; writes to x0 are swallowed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_full <= '0;
      for (int i = 0; i < NREQ; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        // A full buffer has ready low, so grant and load never coincide
        if (w_gnt_vld && (w_gnt == PW'(i))) begin
          r_full[i] <= 1'b0;
        end else if (bus.req_valid[i] && !r_full[i] && (bus.req_addr[i*AW +: AW] != '0)) begin
          r_full[i] <= 1'b1;
          r_addr[i] <= bus.req_addr[i*AW +: AW];
          r_data[i] <= bus.req_data[i*DW +: DW];
        end
      end
    end
  end

  // Registered write port and round-robin pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we3 <= 1'b0;
      r_wa3 <= '0;
      r_wd3 <= '0;
      r_ptr <= '0;
    end else if (w_gnt_vld) begin
      r_we3 <= 1'b1;
      r_wa3 <= r_addr[w_gnt];
      r_wd3 <= r_data[w_gnt];
      r_ptr <= w_ptr_nxt;
    end else begin
      r_we3 <= 1'b0;
    end
  end

  // Pending-write mask: every buffered destination plus the one on the write port
  always_comb begin
    w_pend = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_full[i]) begin
        w_pend[r_addr[i]] = 1'b1;
      end
    end
    if (r_we3) begin
      w_pend[r_wa3] = 1'b1;
    end
    w_pend[0] = 1'b0;
  end

  assign bus.req_ready = ~r_full;
  assign bus.we3       = r_we3;
  assign bus.wa3       = r_wa3;
  assign bus.wd3       = r_wd3;
  assign bus.pend_mask = w_pend;

`ifdef WB_FWD_EN
  // Covers the cycle where the write sits on the port but has not reached the regfile
  assign bus.fwd_rd1 = (r_we3 && (bus.ra1 == r_wa3) && (bus.ra1 != '0)) ? r_wd3 : bus.rf_rd1;
  assign bus.fwd_rd2 = (r_we3 && (bus.ra2 == r_wa3) && (bus.ra2 != '0)) ? r_wd3 : bus.rf_rd2;
`else
  logic w_unused_ra;
  assign w_unused_ra = ^{bus.ra1, bus.ra2};
  assign bus.fwd_rd1 = bus.rf_rd1;
  assign bus.fwd_rd2 = bus.rf_rd2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with NREQ=2, AW=5, DW=32.
module tb_regfile_wb_arbiter;
  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  regfile_wb_arbiter_if #(.NREQ(2), .AW(5), .DW(32)) bus ();

  regfile_wb_arbiter #(.NREQ(2), .AW(5), .DW(32)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
  endtask

  // Async reset pulse placed between clock edges
  task automatic pulse_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    drive_idle();
    bus.rf_rd1 = '0;
    bus.rf_rd2 = '0;
    bus.ra1    = '0;
    bus.ra2    = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_we3", 64'(bus.we3), 64'd0);
    check_eq("rst_wa3", 64'(bus.wa3), 64'd0);
    check_eq("rst_wd3", 64'(bus.wd3), 64'd0);
    check_eq("rst_ready", 64'(bus.req_ready), 64'd3);
    check_eq("rst_pend", 64'(bus.pend_mask), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single write: accept at T, write port in cycle T+1 only
    bus.req_valid       = 2'b01;
    bus.req_addr[4:0]   = 5'd5;
    bus.req_data[31:0]  = 32'hDEADBEEF;
    @(negedge clk);
    drive_idle();
    check_eq("single_we3_T", 64'(bus.we3), 64'd0);
    check_eq("single_ready_T", 64'(bus.req_ready), 64'd2);
    check_eq("single_pend_T", 64'(bus.pend_mask), 64'h20);
    @(negedge clk);
    check_eq("single_we3_T1", 64'(bus.we3), 64'd1);
    check_eq("single_wa3_T1", 64'(bus.wa3), 64'd5);
    check_eq("single_wd3_T1", 64'(bus.wd3), 64'hDEADBEEF);
    check_eq("single_pend_T1", 64'(bus.pend_mask), 64'h20);
    check_eq("single_ready_T1", 64'(bus.req_ready), 64'd3);
    @(negedge clk);
    check_eq("single_we3_T2", 64'(bus.we3), 64'd0);
    check_eq("single_pend_T2", 64'(bus.pend_mask), 64'd0);

    // Tie with pointer at 1 (after granting req0): req1 goes first
    bus.req_valid = 2'b11;
    bus.req_addr  = {5'd4, 5'd3};
    bus.req_data  = {32'd2, 32'd1};
    @(negedge clk);
    drive_idle();
    check_eq("tie1_pend", 64'(bus.pend_mask), 64'h18);
    @(negedge clk);
    check_eq("tie1_first_wa3", 64'(bus.wa3), 64'd4);
    check_eq("tie1_first_wd3", 64'(bus.wd3), 64'd2);
    check_eq("tie1_first_pend", 64'(bus.pend_mask), 64'h18);
    @(negedge clk);
    check_eq("tie1_second_we3", 64'(bus.we3), 64'd1);
    check_eq("tie1_second_wa3", 64'(bus.wa3), 64'd3);
    check_eq("tie1_second_wd3", 64'(bus.wd3), 64'd1);
    @(negedge clk);
    check_eq("tie1_idle_we3", 64'(bus.we3), 64'd0);

    // Contention from reset (pointer 0): addr 3 then addr 4
    pulse_reset();
    @(negedge clk);
    bus.req_valid = 2'b11;
    bus.req_addr  = {5'd4, 5'd3};
    bus.req_data  = {32'd2, 32'd1};
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    check_eq("tie0_first_wa3", 64'(bus.wa3), 64'd3);
    check_eq("tie0_first_wd3", 64'(bus.wd3), 64'd1);
    @(negedge clk);
    check_eq("tie0_second_we3", 64'(bus.we3), 64'd1);
    check_eq("tie0_second_wa3", 64'(bus.wa3), 64'd4);
    check_eq("tie0_second_wd3", 64'(bus.wd3), 64'd2);
    @(negedge clk);
    check_eq("tie0_idle_we3", 64'(bus.we3), 64'd0);

    // Write to x0: handshake completes, nothing is written
    bus.req_valid       = 2'b10;
    bus.req_addr[9:5]   = 5'd0;
    bus.req_data[63:32] = 32'hFFFFFFFF;
    @(negedge clk);
    drive_idle();
    check_eq("x0_ready", 64'(bus.req_ready), 64'd3);
    for (int c = 0; c < 3; c++) begin
      check_eq("x0_we3", 64'(bus.we3), 64'd0);
      check_eq("x0_pend", 64'(bus.pend_mask), 64'd0);
      @(negedge clk);
    end

    // Streaming from reset: 20 back-to-back writes alternating req0/req1
    pulse_reset();
    @(negedge clk);
    bus.req_valid = 2'b11;
    bus.req_addr  = {5'd11, 5'd10};
    bus.req_data  = {32'hBBBB, 32'hAAAA};
    @(negedge clk);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check_eq("stream_we3", 64'(bus.we3), 64'd1);
      check_eq("stream_wa3", 64'(bus.wa3), (n % 2 == 0) ? 64'd10 : 64'd11);
      check_eq("stream_wd3", 64'(bus.wd3), (n % 2 == 0) ? 64'hAAAA : 64'hBBBB);
      check_eq("stream_ready", 64'(bus.req_ready),
               (n == 19) ? 64'd3 : ((n % 2 == 0) ? 64'd1 : 64'd2));
      if (n == 18) drive_idle();
    end
    @(negedge clk);
    check_eq("stream_end_we3", 64'(bus.we3), 64'd0);
    check_eq("stream_end_ready", 64'(bus.req_ready), 64'd3);

    // Reset mid-stream discards the in-flight and buffered writes
    bus.req_valid = 2'b11;
    bus.req_addr  = {5'd13, 5'd12};
    bus.req_data  = {32'h13, 32'h12};
    @(negedge clk);
    check_eq("midrst_both_full", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    check_eq("midrst_pre_we3", 64'(bus.we3), 64'd1);
    reset_n = 1'b0;
    drive_idle();
    #1;
    check_eq("midrst_we3", 64'(bus.we3), 64'd0);
    check_eq("midrst_ready", 64'(bus.req_ready), 64'd3);
    check_eq("midrst_pend", 64'(bus.pend_mask), 64'd0);
    check_eq("midrst_wa3", 64'(bus.wa3), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("postrst_we3", 64'(bus.we3), 64'd0);
      check_eq("postrst_pend", 64'(bus.pend_mask), 64'd0);
    end

    // Forwarding of the write-port value
    bus.req_valid      = 2'b01;
    bus.req_addr[4:0]  = 5'd7;
    bus.req_data[31:0] = 32'h55;
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    check_eq("fwd_setup_wa3", 64'(bus.wa3), 64'd7);
    bus.ra1    = 5'd7;
    bus.rf_rd1 = 32'h11;
    bus.ra2    = 5'd0;
    bus.rf_rd2 = 32'h22;
    #1;
`ifdef WB_FWD_EN
    check_eq("fwd_rd1_hit", 64'(bus.fwd_rd1), 64'h55);
`else
    check_eq("fwd_rd1_hit", 64'(bus.fwd_rd1), 64'h11);
`endif
    check_eq("fwd_rd2_x0", 64'(bus.fwd_rd2), 64'h22);
    bus.ra2 = 5'd7;
    #1;
`ifdef WB_FWD_EN
    check_eq("fwd_rd2_hit", 64'(bus.fwd_rd2), 64'h55);
`else
    check_eq("fwd_rd2_hit", 64'(bus.fwd_rd2), 64'h22);
`endif
    @(negedge clk);
    check_eq("fwd_rd1_idle", 64'(bus.fwd_rd1), 64'h11);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
